// File: rtl/dmem_req_arbiter.sv
// ============================================================================
// dmem_req_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares the single data-memory request port between two requesters
//   (port 0 = LSU, port 1 = debug/DMA). A one-entry output register (OR)
//   drives the memory request. An in-order tracker FIFO of requester IDs
//   routes each in-order memory response back to the port that issued it.
//
// Configuration macro:
//   DMEM_ARB_FIXED_PRIO_EN  - defined: port 0 always wins when both ports
//                             request (no round-robin state).
//                             undefined (default): 2-way round-robin.
//
// Ports:
//   i_clk, i_rst              clock (rising edge), synchronous active-high reset
//   i_req{0,1}_vld            request valid
//   i_req{0,1}_ctrl[3:0]      {vld, mtype, len[1:0]}; the vld bit is ignored
//   i_req{0,1}_addr/_wdata    byte address / write data
//   o_req{0,1}_rdy            request accepted this cycle when vld & rdy
//   o_mem_req_vld/_ctrl/_addr/_wdata   registered memory request
//   i_mem_req_rdy             memory accepts when vld & rdy
//   i_mem_resp_vld            one in-order response per issued request
//   i_mem_resp_rdata          read data
//   o_resp{0,1}_vld           single-cycle response strobe for requester N
//   o_resp_rdata              i_mem_resp_rdata passed through
//   o_err_unexp_resp          sticky: response seen with tracker empty
// ============================================================================
module dmem_req_arbiter #(
    parameter int N_BITS     = 32,
    parameter int MAX_OUTSTD = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_vld,
    input  logic [3:0]        i_req0_ctrl,
    input  logic [N_BITS-1:0] i_req0_addr,
    input  logic [N_BITS-1:0] i_req0_wdata,
    output logic              o_req0_rdy,
    input  logic              i_req1_vld,
    input  logic [3:0]        i_req1_ctrl,
    input  logic [N_BITS-1:0] i_req1_addr,
    input  logic [N_BITS-1:0] i_req1_wdata,
    output logic              o_req1_rdy,
    output logic              o_mem_req_vld,
    output logic [3:0]        o_mem_req_ctrl,
    output logic [N_BITS-1:0] o_mem_req_addr,
    output logic [N_BITS-1:0] o_mem_req_wdata,
    input  logic              i_mem_req_rdy,
    input  logic              i_mem_resp_vld,
    input  logic [N_BITS-1:0] i_mem_resp_rdata,
    output logic              o_resp0_vld,
    output logic              o_resp1_vld,
    output logic [N_BITS-1:0] o_resp_rdata,
    output logic              o_err_unexp_resp
);

    localparam int PW = (MAX_OUTSTD > 1) ? $clog2(MAX_OUTSTD) : 1;
    // One extra bit so the count can hold MAX_OUTSTD (and MAX_OUTSTD+1 in sums).
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] L_MAX = CW'(MAX_OUTSTD);

    // Output register
    logic              r_or_vld;
    logic [2:0]        r_or_ctrl;
    logic [N_BITS-1:0] r_or_addr;
    logic [N_BITS-1:0] r_or_wdata;
    logic              r_or_id;

    // Tracker FIFO of requester IDs
    logic [MAX_OUTSTD-1:0] r_trk_id;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_trk_cnt;

    logic                  r_err;

    logic              w_or_free;
    logic [CW-1:0]     w_outstd;
    logic              w_can_accept;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_acc0;
    logic              w_acc1;
    logic              w_accept;
    logic [2:0]        w_sel_ctrl;
    logic [N_BITS-1:0] w_sel_addr;
    logic [N_BITS-1:0] w_sel_wdata;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_head_id;
    logic              w_unexp;
    logic              w_unused_ok;

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Port that won the last real accept; reset value 1 makes port 0 win first.
    logic              r_rr_last;
`endif

    // The vld bit inside the ctrl bundle is superseded by i_reqN_vld.
    assign w_unused_ok = ^{i_req0_ctrl[3], i_req1_ctrl[3]};

    // The OR can take a new request if it is empty or is draining this cycle,
    // and the total in flight (tracker + OR) leaves room for one more.
    assign w_or_free    = !r_or_vld | i_mem_req_rdy;
    assign w_outstd     = r_trk_cnt + {{(CW-1){1'b0}}, r_or_vld};
    assign w_can_accept = !i_rst & w_or_free & (w_outstd < L_MAX);

    // Grant selection between the two requesters
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (i_req0_vld & i_req1_vld) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            w_grant0 = 1'b1;
            w_grant1 = 1'b0;
`else
            // Alternate: the port that did not win last time gets it now.
            w_grant0 = r_rr_last;
            w_grant1 = !r_rr_last;
`endif
        end else begin
            w_grant0 = i_req0_vld;
            w_grant1 = i_req1_vld;
        end
    end

    assign o_req0_rdy = w_can_accept & w_grant0;
    assign o_req1_rdy = w_can_accept & w_grant1;
    assign w_acc0     = i_req0_vld & o_req0_rdy;
    assign w_acc1     = i_req1_vld & o_req1_rdy;
    assign w_accept   = w_acc0 | w_acc1;

    // Request payload mux for the accepted port
    always_comb begin
        w_sel_ctrl  = 3'b000;
        w_sel_addr  = {N_BITS{1'b0}};
        w_sel_wdata = {N_BITS{1'b0}};
        if (w_acc1) begin
            w_sel_ctrl  = i_req1_ctrl[2:0];
            w_sel_addr  = i_req1_addr;
            w_sel_wdata = i_req1_wdata;
        end else begin
            w_sel_ctrl  = i_req0_ctrl[2:0];
            w_sel_addr  = i_req0_addr;
            w_sel_wdata = i_req0_wdata;
        end
    end

    // Tracker push/pop. A response with an empty tracker is never routed;
    // it is only an error when no push is happening in the same cycle.
    assign w_push    = r_or_vld & i_mem_req_rdy;
    assign w_empty   = (r_trk_cnt == {CW{1'b0}});
    assign w_head_id = r_trk_id[r_rd_ptr];
    assign w_pop     = !i_rst & i_mem_resp_vld & !w_empty;
    assign w_unexp   = i_mem_resp_vld & w_empty & !w_push;

    assign o_resp0_vld  = w_pop & !w_head_id;
    assign o_resp1_vld  = w_pop & w_head_id;
    assign o_resp_rdata = i_mem_resp_rdata;

    assign o_mem_req_vld    = r_or_vld;
    assign o_mem_req_ctrl   = {r_or_vld, r_or_ctrl};
    assign o_mem_req_addr   = r_or_addr;
    assign o_mem_req_wdata  = r_or_wdata;
    assign o_err_unexp_resp = r_err;

    // Output register: load on accept, clear when drained without reload,
    // otherwise hold stable (stall).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_or_vld   <= 1'b0;
            r_or_ctrl  <= 3'b000;
            r_or_addr  <= {N_BITS{1'b0}};
            r_or_wdata <= {N_BITS{1'b0}};
            r_or_id    <= 1'b0;
        end else if (w_accept) begin
            r_or_vld   <= 1'b1;
            r_or_ctrl  <= w_sel_ctrl;
            r_or_addr  <= w_sel_addr;
            r_or_wdata <= w_sel_wdata;
            r_or_id    <= w_acc1;
        end else if (i_mem_req_rdy) begin
            r_or_vld   <= 1'b0;
        end
    end

    // Tracker FIFO: IDs enter when the OR issues and leave on each response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_trk_id  <= {MAX_OUTSTD{1'b0}};
            r_wr_ptr  <= {PW{1'b0}};
            r_rd_ptr  <= {PW{1'b0}};
            r_trk_cnt <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_trk_id[r_wr_ptr] <= r_or_id;
                r_wr_ptr           <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_trk_cnt <= r_trk_cnt + CW'(1);
                2'b01:   r_trk_cnt <= r_trk_cnt - CW'(1);
                default: r_trk_cnt <= r_trk_cnt;
            endcase
        end
    end

    // Sticky unexpected-response flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (w_unexp) begin
            r_err <= 1'b1;
        end
    end

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Round-robin state only moves on a real accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_last <= 1'b1;
        end else if (w_accept) begin
            r_rr_last <= w_acc1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_req_arbiter.sv
module tb_dmem_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_vld, req1_vld;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
    logic        req0_rdy, req1_rdy;
    logic        mem_req_vld;
    logic [3:0]  mem_req_ctrl;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_req_rdy;
    logic        mem_resp_vld;
    logic [31:0] mem_resp_rdata;
    logic        resp0_vld, resp1_vld;
    logic [31:0] resp_rdata;
    logic        err_unexp;

    int n_checks = 0;
    int n_errors = 0;

    int   exp_grant [4];
    int   seq_port  [4];
    logic seq_wr    [4];

    always #5 clk = ~clk;

    dmem_req_arbiter #(.N_BITS(32), .MAX_OUTSTD(2)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_vld(req0_vld), .i_req0_ctrl(req0_ctrl), .i_req0_addr(req0_addr),
        .i_req0_wdata(req0_wdata), .o_req0_rdy(req0_rdy),
        .i_req1_vld(req1_vld), .i_req1_ctrl(req1_ctrl), .i_req1_addr(req1_addr),
        .i_req1_wdata(req1_wdata), .o_req1_rdy(req1_rdy),
        .o_mem_req_vld(mem_req_vld), .o_mem_req_ctrl(mem_req_ctrl),
        .o_mem_req_addr(mem_req_addr), .o_mem_req_wdata(mem_req_wdata),
        .i_mem_req_rdy(mem_req_rdy),
        .i_mem_resp_vld(mem_resp_vld), .i_mem_resp_rdata(mem_resp_rdata),
        .o_resp0_vld(resp0_vld), .o_resp1_vld(resp1_vld),
        .o_resp_rdata(resp_rdata), .o_err_unexp_resp(err_unexp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_vld = 1'b0; req1_vld = 1'b0;
        req0_ctrl = 4'h0; req1_ctrl = 4'h0;
        req0_addr = 32'h0; req1_addr = 32'h0;
        req0_wdata = 32'h0; req1_wdata = 32'h0;
        mem_req_rdy = 1'b0; mem_resp_vld = 1'b0; mem_resp_rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // mode 0: both ports request continuously; mode 1: seq_port[] one at a time.
    // Memory always ready; a response is returned whenever something is in flight.
    task automatic run_traffic(input int mode, input int n_acc, input string name);
        int   k;
        int   n_out;
        int   cyc;
        int   q[$];
        int   exp_port;
        logic issue;
        logic resp;
        logic done;
        k = 0; n_out = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 60) begin
            resp           = (n_out > 0);
            mem_resp_vld   = resp;
            mem_resp_rdata = 32'hA500_0000 | 32'(cyc);
            mem_req_rdy    = 1'b1;
            if (k < n_acc) begin
                if (mode == 0) begin
                    req0_vld = 1'b1; req1_vld = 1'b1;
                    req0_ctrl = 4'h0; req1_ctrl = 4'h0;
                end else begin
                    req0_vld  = (seq_port[k] == 0);
                    req1_vld  = (seq_port[k] == 1);
                    req0_ctrl = {1'b1, seq_wr[k], 2'b10};
                    req1_ctrl = {1'b1, seq_wr[k], 2'b10};
                end
                req0_addr = 32'h1000 + 32'(k);
                req1_addr = 32'h2000 + 32'(k);
            end else begin
                req0_vld = 1'b0; req1_vld = 1'b0;
            end
            #1;
            if (resp) begin
                exp_port = (q.size() > 0) ? q.pop_front() : 0;
                check($sformatf("%s_resp_route", name), {30'd0, resp1_vld, resp0_vld},
                      (exp_port == 1) ? 32'd2 : 32'd1);
                check($sformatf("%s_resp_rdata", name), resp_rdata, 32'hA500_0000 | 32'(cyc));
            end
            if (req0_rdy | req1_rdy) begin
                check($sformatf("%s_grant%0d", name, k), {31'd0, req1_rdy}, 32'(exp_grant[k]));
                check($sformatf("%s_rdy_onehot%0d", name, k), {31'd0, req0_rdy & req1_rdy}, 32'd0);
                q.push_back(exp_grant[k]);
                k++;
            end
            issue = mem_req_vld & mem_req_rdy;
            tick();
            cyc++;
            if (issue) n_out++;
            if (resp)  n_out--;
            done = (k == n_acc) && (n_out == 0) && !mem_req_vld;
        end
        check($sformatf("%s_completed", name), {31'd0, done}, 32'd1);
        idle_inputs();
    endtask

    initial begin
        // ---------------- reset state ----------------
        idle_inputs();
        rst = 1'b1;
        req0_vld = 1'b1; req0_addr = 32'h55; mem_resp_vld = 1'b1;
        tick();
        tick();
        check("rst_mem_req_vld", mem_req_vld, 32'd0);
        check("rst_mem_req_ctrl", mem_req_ctrl, 32'd0);
        check("rst_mem_req_addr", mem_req_addr, 32'd0);
        check("rst_mem_req_wdata", mem_req_wdata, 32'd0);
        check("rst_req0_rdy", req0_rdy, 32'd0);
        check("rst_req1_rdy", req1_rdy, 32'd0);
        check("rst_resp0_vld", resp0_vld, 32'd0);
        check("rst_resp1_vld", resp1_vld, 32'd0);
        rst = 1'b0;
        idle_inputs();
        tick();
        check("rst_err", err_unexp, 32'd0);

        // ---------------- single read ----------------
        req0_vld = 1'b1; req0_ctrl = 4'b0000; req0_addr = 32'h100; mem_req_rdy = 1'b1;
        #1;
        check("rd_req0_rdy", req0_rdy, 32'd1);
        check("rd_req1_rdy", req1_rdy, 32'd0);
        tick();
        req0_vld = 1'b0;
        check("rd_mem_req_vld", mem_req_vld, 32'd1);
        check("rd_mem_req_addr", mem_req_addr, 32'h100);
        check("rd_mem_req_ctrl", mem_req_ctrl, 32'b1000);
        tick();
        check("rd_mem_req_drained", mem_req_vld, 32'd0);
        mem_resp_vld = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF;
        #1;
        check("rd_resp0_vld", resp0_vld, 32'd1);
        check("rd_resp1_vld", resp1_vld, 32'd0);
        check("rd_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
        tick();
        mem_resp_vld = 1'b0;
        #1;
        check("rd_resp0_done", resp0_vld, 32'd0);
        check("rd_err", err_unexp, 32'd0);

        // ---------------- contention ----------------
        do_reset();
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_grant[0] = 0; exp_grant[1] = 0; exp_grant[2] = 0; exp_grant[3] = 0;
`else
        exp_grant[0] = 0; exp_grant[1] = 1; exp_grant[2] = 0; exp_grant[3] = 1;
`endif
        run_traffic(0, 4, "rr");

        // ---------------- ordering: p1 wr, p0 rd, p1 rd ----------------
        do_reset();
        seq_port[0] = 1; seq_wr[0] = 1'b1; exp_grant[0] = 1;
        seq_port[1] = 0; seq_wr[1] = 1'b0; exp_grant[1] = 0;
        seq_port[2] = 1; seq_wr[2] = 1'b0; exp_grant[2] = 1;
        run_traffic(1, 3, "ord");

        // ---------------- stall ----------------
        do_reset();
        req0_vld = 1'b1; req0_ctrl = 4'b0100; req0_addr = 32'h200; req0_wdata = 32'h1234_5678;
        mem_req_rdy = 1'b0;
        #1;
        check("stall_load_rdy0", req0_rdy, 32'd1);
        tick();
        req0_vld = 1'b0;
        req1_vld = 1'b1; req1_ctrl = 4'b0000; req1_addr = 32'h300;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d_vld", i), mem_req_vld, 32'd1);
            check($sformatf("stall%0d_addr", i), mem_req_addr, 32'h200);
            check($sformatf("stall%0d_wdata", i), mem_req_wdata, 32'h1234_5678);
            check($sformatf("stall%0d_ctrl", i), mem_req_ctrl, 32'b1100);
            check($sformatf("stall%0d_rdy", i), {req1_rdy, req0_rdy}, 32'd0);
            tick();
        end
        mem_req_rdy = 1'b1;
        #1;
        check("stall_release_rdy1", req1_rdy, 32'd1);
        tick();
        req1_vld = 1'b0;
        check("stall_reload_vld", mem_req_vld, 32'd1);
        check("stall_reload_addr", mem_req_addr, 32'h300);
        check("stall_reload_ctrl", mem_req_ctrl, 32'b1000);
        mem_resp_vld = 1'b1;
        #1;
        check("stall_resp_first", {resp1_vld, resp0_vld}, 32'b01);
        tick();
        #1;
        check("stall_resp_second", {resp1_vld, resp0_vld}, 32'b10);
        tick();
        mem_resp_vld = 1'b0;

        // ---------------- full tracker ----------------
        req0_vld = 1'b1; req0_addr = 32'h400; mem_req_rdy = 1'b1;
        #1;
        check("full_acc_a", req0_rdy, 32'd1);
        tick();
        #1;
        check("full_acc_b", req0_rdy, 32'd1);
        tick();
        #1;
        check("full_or_blocks", req0_rdy, 32'd0);
        tick();
        req1_vld = 1'b1;
        #1;
        check("full_both_blocked", {req1_rdy, req0_rdy}, 32'd0);
        tick();
        mem_resp_vld = 1'b1;
        #1;
        check("full_pop_oldest", {resp1_vld, resp0_vld}, 32'b01);
        check("full_rdy_same_cycle", {req1_rdy, req0_rdy}, 32'd0);
        tick();
        mem_resp_vld = 1'b0;
        #1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        check("full_rdy_returns", {req1_rdy, req0_rdy}, 32'b01);
`else
        check("full_rdy_returns", {req1_rdy, req0_rdy}, 32'b10);
`endif
        req0_vld = 1'b0; req1_vld = 1'b0;
        tick();
        mem_resp_vld = 1'b1;
        #1;
        check("full_pop_second", {resp1_vld, resp0_vld}, 32'b01);
        tick();
        mem_resp_vld = 1'b0;

        // ---------------- unexpected response ----------------
        mem_resp_vld = 1'b1; mem_resp_rdata = 32'h0BAD_0BAD;
        #1;
        check("unexp_no_resp", {resp1_vld, resp0_vld}, 32'd0);
        check("unexp_err_before", err_unexp, 32'd0);
        tick();
        mem_resp_vld = 1'b0;
        check("unexp_err_set", err_unexp, 32'd1);
        tick();
        tick();
        check("unexp_err_sticky", err_unexp, 32'd1);

        // ---------------- reset mid-flight ----------------
        req0_vld = 1'b1; req0_addr = 32'h500; req0_ctrl = 4'b0000; mem_req_rdy = 1'b0;
        tick();
        check("mid_issue_vld", mem_req_vld, 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_vld", mem_req_vld, 32'd0);
        check("mid_rst_addr", mem_req_addr, 32'd0);
        check("mid_rst_ctrl", mem_req_ctrl, 32'd0);
        check("mid_rst_err", err_unexp, 32'd0);
        check("mid_rst_rdy0", req0_rdy, 32'd0);
        rst = 1'b0;
        req0_vld = 1'b0;
        mem_resp_vld = 1'b1;
        #1;
        check("mid_late_resp", {resp1_vld, resp0_vld}, 32'd0);
        tick();
        mem_resp_vld = 1'b0;
        check("mid_late_err", err_unexp, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
